// File: rtl/modexp_engine.sv
// Modular exponentiation engine: left-to-right square-and-multiply over an
// interleaved shift-add modular multiplier that consumes one multiplier bit per cycle.
module modexp_engine #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] base_q, exp_q, n_q;
    logic [WIDTH-1:0] acc, bred;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt, bit_idx;

    logic [WIDTH-1:0] op_a, op_b, b_shift, e_shift;
    logic [WIDTH:0]   nx, dbl, r1, r2, r3, step;
    logic             b_bit, exp_bit, last, bit_last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (modulus == '0) ? DONE : REDUCE;
            REDUCE:  if (last) state_next = SQUARE;
            SQUARE:  if (last) state_next = exp_bit ? MULT : (bit_last ? DONE : SQUARE);
            MULT:    if (last) state_next = bit_last ? DONE : SQUARE;
            DONE:    if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One step of a*b mod n: double, reduce, then conditionally add a and reduce.
    always_comb begin
        op_a = acc;
        op_b = acc;
        case (state)
            REDUCE:  begin op_a = WIDTH'(1); op_b = base_q; end
            MULT:    begin op_a = bred;      op_b = acc;    end
            default: begin op_a = acc;       op_b = acc;    end
        endcase
        b_shift  = op_b >> (CW'(WIDTH - 1) - cnt);
        b_bit    = b_shift[0];
        e_shift  = exp_q >> bit_idx;
        exp_bit  = e_shift[0];
        last     = (cnt == CW'(WIDTH - 1));
        bit_last = (bit_idx == '0);
        nx       = {1'b0, n_q};
        dbl      = {r[WIDTH-1:0], 1'b0};
        r1       = (dbl >= nx) ? dbl - nx : dbl;
        r2       = r1 + {1'b0, op_a};
        r3       = (r2 >= nx) ? r2 - nx : r2;
        step     = b_bit ? r3 : r1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            acc     <= '0;
            bred    <= '0;
            r       <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_q  <= base;
                        exp_q   <= exp;
                        n_q     <= modulus;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        r       <= '0;
                        bit_idx <= CW'(WIDTH - 1);
                        // The zero-modulus path dwells one extra cycle in DONE.
                        cnt     <= (modulus == '0) ? CW'(1) : '0;
                    end
                end
                REDUCE, SQUARE, MULT: begin
                    if (last) begin
                        r   <= '0;
                        cnt <= '0;
                        if (state == REDUCE) begin
                            bred <= step[WIDTH-1:0];
                            acc  <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                        end else begin
                            acc <= step[WIDTH-1:0];
                            if (state == MULT || !exp_bit) bit_idx <= bit_idx - CW'(1);
                        end
                    end else begin
                        r   <= step;
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        result <= (n_q == '0) ? '0 : acc;
                        err    <= (n_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_engine.sv
// Directed self-checking bench for modexp_engine using textbook RSA vectors
// (n=3233, e=17, d=2753) and the boundary cases of the exponentiator.
module tb_modexp_engine;
    localparam int W = 26;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] base, exp, modulus;
    logic         busy, done, err;
    logic [W-1:0] result;

    int assert_count = 0;
    int fail_count = 0;

    modexp_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp),
        .modulus(modulus), .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    // Accept one operation and count edges until done; lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          output int lat, output logic [W-1:0] res, output logic e_o,
                          output bit busy_ok);
        @(negedge clk);
        base = b; exp = e; modulus = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_ok = busy;
        lat = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        res = result;
        e_o = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; base = 26'd65; exp = 26'd17; modulus = 26'd3233;
        repeat (3) @(posedge clk);
        #1;
        assert_count++;
        if ({busy, done, err, result} !== {3'b000, 26'd0}) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b result=%0d, want all 0", busy, done, err, result);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        assert_count++;
        if (busy !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] b, input logic [W-1:0] e,
                            input logic [W-1:0] m, input logic [W-1:0] want_res,
                            input logic want_err, input int want_lat);
        int lat;
        logic [W-1:0] res;
        logic e_o;
        bit busy_ok;
        run_op(b, e, m, lat, res, e_o, busy_ok);
        assert_count++;
        if (lat !== want_lat) begin
            fail_count++;
            $display("[TB] FAIL %s_latency: got %0d, want %0d", name, lat, want_lat);
        end
        assert_count++;
        if (res !== want_res || e_o !== want_err) begin
            fail_count++;
            $display("[TB] FAIL %s_result: got result=%0d err=%b, want result=%0d err=%b", name, res, e_o, want_res, want_err);
        end
        assert_count++;
        if (!busy_ok || busy !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL %s_busy: got busy_throughout=%b busy_at_done=%b, want 1 and 0", name, busy_ok, busy);
        end
    endtask

    task automatic test_encrypt();
        check_op("encrypt", 26'd65, 26'd17, 26'd3233, 26'd2790, 1'b0, 755);
        @(posedge clk);
        #1;
        assert_count++;
        if (done !== 1'b0 || result !== 26'd2790) begin
            fail_count++;
            $display("[TB] FAIL done_pulse: got done=%b result=%0d one cycle later, want done=0 result=2790", done, result);
        end
    endtask

    task automatic test_decrypt();
        check_op("decrypt", 26'd2790, 26'd2753, 26'd3233, 26'd65, 1'b0, 833);
    endtask

    task automatic test_boundaries();
        check_op("exp_zero", 26'd5, 26'd0, 26'd7, 26'd1, 1'b0, 703);
        check_op("base_ge_n", 26'd3300, 26'd1, 26'd3233, 26'd67, 1'b0, 729);
        check_op("mod_one", 26'd5, 26'd3, 26'd1, 26'd0, 1'b0, 755);
    endtask

    task automatic test_mod_zero();
        check_op("mod_zero", 26'd9, 26'd4, 26'd0, 26'd0, 1'b1, 2);
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        @(negedge clk);
        base = 26'd65; exp = 26'd17; modulus = 26'd3233; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (i == 100) begin
                base = 26'd2; exp = 26'd3; modulus = 26'd11; start = 1'b1;
            end else if (i == 103) begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        assert_count++;
        if (lat !== 755 || result !== 26'd2790) begin
            fail_count++;
            $display("[TB] FAIL start_ignored: got latency=%0d result=%0d, want 755 and 2790", lat, result);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [W-1:0] res;
        logic e_o;
        bit busy_ok;
        bit saw_done = 1'b0;
        @(negedge clk);
        base = 26'd65; exp = 26'd17; modulus = 26'd3233; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (299) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        assert_count++;
        if ({busy, done, err, result} !== {3'b000, 26'd0}) begin
            fail_count++;
            $display("[TB] FAIL abort_outputs: got busy=%b done=%b err=%b result=%0d, want all 0", busy, done, err, result);
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        assert_count++;
        if (saw_done) begin
            fail_count++;
            $display("[TB] FAIL abort_no_done: got activity after aborted run, want none");
        end
        check_op("after_abort", 26'd65, 26'd17, 26'd3233, 26'd2790, 1'b0, 755);
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", 26'd9, 26'd4, 26'd0, 26'd0, 1'b1, 2);
        check_op("b2b_second", 26'd4, 26'd13, 26'd497, 26'd445, 1'b0, 781);
    endtask

    initial begin
        start = 1'b0; base = '0; exp = '0; modulus = '0; rst = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_boundaries();
        test_mod_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/modexp_engine.md
MODEXP_ENGINE -- requirements
Module: modexp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 26, which sets the operand, modulus and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to compute; sampled only in IDLE.
REQ-005 SHALL have port base, input, WIDTH bits: message letter or ciphertext; any value, including values >= modulus.
REQ-006 SHALL have port exp, input, WIDTH bits: exponent (e or d).
REQ-007 SHALL have port modulus, input, WIDTH bits: RSA modulus n.
REQ-008 SHALL have port busy, output, 1 bit: high from the accepting edge until the edge on which done rises.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-010 SHALL have port result, output, WIDTH bits: (base^exp) mod modulus; held from done until the next accepted start.
REQ-011 SHALL have port err, output, 1 bit: set together with done when modulus==0; held with result.

Function
REQ-012 SHALL implement states IDLE, REDUCE, SQUARE, MULT and DONE.
REQ-013 SHALL, in IDLE with start==1, register base, exp and modulus, clear err, assert busy, and enter REDUCE; if modulus==0 it SHALL instead go to DONE with result=0 and err=1.
REQ-014 SHALL ignore start in every state other than IDLE; operand changes after acceptance SHALL have no effect.
REQ-015 SHALL perform every modular product a*b mod n (with a<n) by interleaved shift-add, one b-bit per cycle, MSB first: r=2r, subtract n if >=n; then if the bit is 1, r=r+a, subtract n if >=n.
REQ-016 SHALL run each modular product for exactly WIDTH cycles.
REQ-017 SHALL use WIDTH+1-bit intermediates so that no sum overflows for any modulus up to 2^WIDTH-1.
REQ-018 SHALL, in REDUCE, compute bred = 1*base mod n (a=1, b=base), then initialise acc = 1 mod n (0 when n==1).
REQ-019 SHALL scan the exponent bits from index WIDTH-1 down to 0.
REQ-020 SHALL, for each exponent bit, compute acc=acc*acc mod n in SQUARE and then, only when that bit is 1, compute acc=acc*bred mod n in MULT.
REQ-021 SHALL skip MULT entirely for exponent bits equal to 0.
REQ-022 SHALL, after bit 0, enter DONE for one cycle: done=1, busy=0, result=acc; then return to IDLE.
REQ-023 SHALL make latency deterministic: done is high in the cycle after edge L = WIDTH*(WIDTH+1+popcount(exp)) + 1, counted from the accepting edge (edge 0).
REQ-024 SHALL use L = 2 for the modulus==0 path.
REQ-025 SHALL return result=1 mod n when exp==0, and result=0 when n==1.
REQ-026 SHALL allow start to be accepted on the first IDLE cycle after DONE, giving back-to-back operations.

Reset
REQ-027 SHALL, when rst==1 at a clock edge, force state IDLE, busy=0, done=0, result=0, err=0, and clear all counters and datapath registers.
REQ-028 SHALL give rst priority over start and over any in-flight operation; an aborted operation SHALL produce no done.
REQ-029 SHALL ignore start while rst==1, and accept it from the first edge with rst==0.

Verification
REQ-030 SHALL verify encryption: base=65, exp=17, modulus=3233 -> result=2790, err=0, done exactly 755 edges after acceptance, busy high throughout.
REQ-031 SHALL verify decryption: base=2790, exp=2753, modulus=3233 -> result=65, with done at the latency given by REQ-023.
REQ-032 SHALL verify boundaries:
- exp=0, base=5, modulus=7 -> result=1, done after 703 edges.
- base=3300, exp=1, modulus=3233 -> result=67.
- modulus=1 -> result=0.
REQ-033 SHALL verify modulus=0, any base/exp -> done 2 edges after acceptance, err=1, result=0.
REQ-034 SHALL verify start pulsed again mid-operation with different operands -> ignored, original result delivered.
REQ-035 SHALL verify rst asserted in cycle 300 of the 65/17/3233 run -> all outputs 0 next cycle, no done; a fresh start then yields 2790.
